// File: rtl/updown_cnt_tracker.sv
// Downstream monitor for a 4-bit up/down counter: classifies each valid step,
// extends the count into a signed multi-turn position and flags illegal jumps.
module updown_cnt_tracker #(
    parameter int WRAP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               cnt_in,
    input  logic                     cnt_vld,
    input  logic                     clr,
    output logic                     dir_up,
    output logic                     dir_dn,
    output logic                     ovf,
    output logic                     unf,
    output logic                     rsync,
    output logic signed [WRAP_W-1:0] wrap_cnt,
    output logic signed [WRAP_W+3:0] pos,
    output logic                     err,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;

    state_t            state, state_nxt;
    logic [3:0]        prev, prev_nxt;
    logic [WRAP_W-1:0] wrap_nxt;
    logic              err_nxt;
    logic              up_nxt, dn_nxt, ovf_nxt, unf_nxt, rsync_nxt;
    logic [3:0]        diff;

    always_comb begin
        state_nxt = state;
        prev_nxt  = prev;
        wrap_nxt  = wrap_cnt;
        err_nxt   = err;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        rsync_nxt = 1'b0;
        diff      = cnt_in - prev;

        if (clr) begin
            state_nxt = IDLE;
            prev_nxt  = '0;
            wrap_nxt  = '0;
            err_nxt   = 1'b0;
        end else if (cnt_vld) begin
            case (state)
                IDLE: begin
                    prev_nxt  = cnt_in;
                    state_nxt = TRACK;
                end
                TRACK: begin
                    // Unit steps are checked before the zero test so 1->0 and 15->0 stay steps.
                    if (diff == 4'd0) begin
                        prev_nxt = prev;
                    end else if (diff == 4'd1) begin
                        up_nxt   = 1'b1;
                        prev_nxt = cnt_in;
                        if (prev == 4'hF) begin
                            ovf_nxt  = 1'b1;
                            wrap_nxt = wrap_cnt + WRAP_W'(1);
                        end
                    end else if (diff == 4'hF) begin
                        dn_nxt   = 1'b1;
                        prev_nxt = cnt_in;
                        if (prev == 4'h0) begin
                            unf_nxt  = 1'b1;
                            wrap_nxt = wrap_cnt - WRAP_W'(1);
                        end
                    end else if (cnt_in == 4'd0) begin
                        rsync_nxt = 1'b1;
                        wrap_nxt  = '0;
                        prev_nxt  = '0;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ERR;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            prev     <= '0;
            wrap_cnt <= '0;
            err      <= 1'b0;
            dir_up   <= 1'b0;
            dir_dn   <= 1'b0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            rsync    <= 1'b0;
        end else begin
            state    <= state_nxt;
            prev     <= prev_nxt;
            wrap_cnt <= wrap_nxt;
            err      <= err_nxt;
            dir_up   <= up_nxt;
            dir_dn   <= dn_nxt;
            ovf      <= ovf_nxt;
            unf      <= unf_nxt;
            rsync    <= rsync_nxt;
        end
    end

    assign pos  = {wrap_cnt, prev};
    assign busy = (state == TRACK);

endmodule

// File: tb/tb_updown_cnt_tracker.sv
// Randomized and scripted bench for updown_cnt_tracker against an integer
// position model of the tracker.
module tb_updown_cnt_tracker;

    localparam int WRAP_W = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [3:0]               cnt_in;
    logic                     cnt_vld;
    logic                     clr;
    logic                     dir_up, dir_dn, ovf, unf, rsync, err, busy;
    logic signed [WRAP_W-1:0] wrap_cnt;
    logic signed [WRAP_W+3:0] pos;

    updown_cnt_tracker #(.WRAP_W(WRAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_vld(cnt_vld), .clr(clr),
        .dir_up(dir_up), .dir_dn(dir_dn), .ovf(ovf), .unf(unf), .rsync(rsync),
        .wrap_cnt(wrap_cnt), .pos(pos), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_TRACK, M_ERR} mstate_t;

    mstate_t ms;
    int      mp, mw;
    bit      me, e_up, e_dn, e_ovf, e_unf, e_rs;
    int      n_vec = 0;
    int      n_bad = 0;

    function automatic int wrapw(input int x);
        int span = 1 << WRAP_W;
        int r = ((x % span) + span) % span;
        if (r >= span / 2) r -= span;
        return r;
    endfunction

    task automatic model_reset();
        ms = M_IDLE; mp = 0; mw = 0; me = 0;
        {e_up, e_dn, e_ovf, e_unf, e_rs} = '0;
    endtask

    // Drive one sample, clock it in, advance the model, then settle past the edge.
    task automatic apply(input int c, input bit v, input bit k);
        @(negedge clk);
        cnt_in = 4'(c); cnt_vld = v; clr = k;
        @(posedge clk);
        {e_up, e_dn, e_ovf, e_unf, e_rs} = '0;
        if (k) begin
            ms = M_IDLE; mp = 0; mw = 0; me = 0;
        end else if (v && ms == M_IDLE) begin
            mp = c; ms = M_TRACK;
        end else if (v && ms == M_TRACK) begin
            if (c == mp) begin
                e_up = 0;
            end else if (c == (mp + 1) % 16) begin
                e_up = 1;
                if (mp == 15) begin e_ovf = 1; mw = wrapw(mw + 1); end
                mp = c;
            end else if (c == (mp + 15) % 16) begin
                e_dn = 1;
                if (mp == 0) begin e_unf = 1; mw = wrapw(mw - 1); end
                mp = c;
            end else if (c == 0) begin
                e_rs = 1; mw = 0; mp = 0;
            end else begin
                me = 1; ms = M_ERR;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cnt_in = '0; cnt_vld = 1'b0; clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== 7'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b, want 0000000", {dir_up, dir_dn, ovf, unf, rsync, err, busy});
        end
        n_vec++;
        if (pos !== '0 || wrap_cnt !== '0) begin
            n_bad++; $display("FAIL reset_pos: got pos=%0d wrap=%0d, want 0/0", pos, wrap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        for (int unsigned i = 0; i < 18; i++) begin
            apply(i % 16, 1, 0);
            n_vec++;
            if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK}) begin
                n_bad++; $display("FAIL count_up_flags step %0d: got %b, want %b", i,
                    {dir_up, dir_dn, ovf, unf, rsync, err, busy}, {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK});
            end
            n_vec++;
            if (int'(pos) !== mw * 16 + mp || int'(wrap_cnt) !== mw) begin
                n_bad++; $display("FAIL count_up_pos step %0d: got pos=%0d wrap=%0d, want %0d/%0d", i, pos, wrap_cnt, mw * 16 + mp, mw);
            end
        end
        n_vec++;
        if (int'(pos) !== 17 || int'(wrap_cnt) !== 1) begin
            n_bad++; $display("FAIL count_up_final: got pos=%0d wrap=%0d, want 17/1", pos, wrap_cnt);
        end
    endtask

    task automatic test_underflow();
        int seq[4] = '{0, 0, 15, 14};
        bit k[4]   = '{1, 0, 0, 0};
        for (int unsigned i = 0; i < 4; i++) begin
            apply(seq[i], 1, k[i]);
            n_vec++;
            if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK}) begin
                n_bad++; $display("FAIL underflow_flags step %0d: got %b, want %b", i,
                    {dir_up, dir_dn, ovf, unf, rsync, err, busy}, {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK});
            end
            n_vec++;
            if (int'(pos) !== mw * 16 + mp || int'(wrap_cnt) !== mw) begin
                n_bad++; $display("FAIL underflow_pos step %0d: got pos=%0d wrap=%0d, want %0d/%0d", i, pos, wrap_cnt, mw * 16 + mp, mw);
            end
            if (i == 2) begin
                n_vec++;
                if (unf !== 1'b1 || dir_dn !== 1'b1 || int'(pos) !== -1 || wrap_cnt !== 8'hFF) begin
                    n_bad++; $display("FAIL underflow_after15: got unf=%b dn=%b pos=%0d, want 1/1/-1", unf, dir_dn, pos);
                end
            end
        end
        n_vec++;
        if (int'(pos) !== -2 || unf !== 1'b0 || dir_dn !== 1'b1) begin
            n_bad++; $display("FAIL underflow_after14: got pos=%0d unf=%b dn=%b, want -2/0/1", pos, unf, dir_dn);
        end
    endtask

    task automatic test_rsync();
        apply(0, 1, 1);
        apply(0, 1, 0);
        for (int unsigned i = 0; i < 41; i++) begin
            apply((i + 1) % 16, 1, 0);
            n_vec++;
            if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK}) begin
                n_bad++; $display("FAIL rsync_build_flags step %0d: got %b, want %b", i,
                    {dir_up, dir_dn, ovf, unf, rsync, err, busy}, {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK});
            end
        end
        n_vec++;
        if (int'(wrap_cnt) !== 2 || int'(pos) !== 41) begin
            n_bad++; $display("FAIL rsync_build: got pos=%0d wrap=%0d, want 41/2", pos, wrap_cnt);
        end
        apply(0, 1, 0);
        n_vec++;
        if (rsync !== 1'b1 || {dir_up, dir_dn, ovf, unf} !== 4'b0 || pos !== '0 || wrap_cnt !== '0) begin
            n_bad++; $display("FAIL rsync_hit: got rsync=%b ud=%b%b pos=%0d wrap=%0d, want 1/00/0/0", rsync, dir_up, dir_dn, pos, wrap_cnt);
        end
        apply(1, 1, 0);
        n_vec++;
        if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== 7'b1000001) begin
            n_bad++; $display("FAIL rsync_next: got %b, want 1000001", {dir_up, dir_dn, ovf, unf, rsync, err, busy});
        end
    endtask

    task automatic test_err();
        int seq[7] = '{0, 3, 7, 8, 9, 0, 5};
        bit k[7]   = '{1, 0, 0, 0, 0, 1, 0};
        for (int unsigned i = 0; i < 7; i++) begin
            apply(seq[i], 1, k[i]);
            n_vec++;
            if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK}) begin
                n_bad++; $display("FAIL err_flags step %0d: got %b, want %b", i,
                    {dir_up, dir_dn, ovf, unf, rsync, err, busy}, {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK});
            end
            n_vec++;
            if (int'(pos) !== mw * 16 + mp) begin
                n_bad++; $display("FAIL err_pos step %0d: got %0d, want %0d", i, pos, mw * 16 + mp);
            end
            if (i == 4) begin
                n_vec++;
                if (err !== 1'b1 || busy !== 1'b0 || int'(pos) !== 3) begin
                    n_bad++; $display("FAIL err_frozen: got err=%b busy=%b pos=%0d, want 1/0/3", err, busy, pos);
                end
            end
        end
    endtask

    task automatic test_hold_vld();
        int seq[5] = '{0, 4, 4, 5, 5};
        bit v[5]   = '{1, 1, 1, 0, 1};
        bit k[5]   = '{1, 0, 0, 0, 0};
        for (int unsigned i = 0; i < 5; i++) begin
            apply(seq[i], v[i], k[i]);
            n_vec++;
            if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK}) begin
                n_bad++; $display("FAIL hold_flags step %0d: got %b, want %b", i,
                    {dir_up, dir_dn, ovf, unf, rsync, err, busy}, {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK});
            end
        end
        n_vec++;
        if (dir_up !== 1'b1 || int'(pos) !== 5) begin
            n_bad++; $display("FAIL hold_final: got up=%b pos=%0d, want 1/5", dir_up, pos);
        end
    endtask

    task automatic test_wrap_limit();
        apply(0, 1, 1);
        apply(0, 1, 0);
        for (int unsigned i = 0; i < 128 * 16; i++) begin
            apply((i + 1) % 16, 1, 0);
            n_vec++;
            if (int'(wrap_cnt) !== mw || {ovf, dir_up} !== {e_ovf, e_up}) begin
                n_bad++; $display("FAIL wrap_limit step %0d: got wrap=%0d ovf=%b, want %0d/%b", i, wrap_cnt, ovf, mw, e_ovf);
            end
        end
        n_vec++;
        if (int'(wrap_cnt) !== -128) begin
            n_bad++; $display("FAIL wrap_max_plus1: got %0d, want -128", wrap_cnt);
        end
        apply(15, 1, 0);
        n_vec++;
        if (int'(wrap_cnt) !== 127 || unf !== 1'b1) begin
            n_bad++; $display("FAIL wrap_min_minus1: got wrap=%0d unf=%b, want 127/1", wrap_cnt, unf);
        end
    endtask

    task automatic test_async_reset();
        apply(0, 1, 1);
        for (int unsigned i = 0; i < 49; i++) apply(i % 16, 1, 0);
        n_vec++;
        if (int'(wrap_cnt) !== 3) begin
            n_bad++; $display("FAIL areset_build: got wrap=%0d, want 3", wrap_cnt);
        end
        @(negedge clk);
        cnt_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== 7'b0 || pos !== '0 || wrap_cnt !== '0) begin
            n_bad++; $display("FAIL areset_immediate: got flags=%b pos=%0d wrap=%0d, want 0/0/0",
                {dir_up, dir_dn, ovf, unf, rsync, err, busy}, pos, wrap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(7, 1, 0);
        n_vec++;
        if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== 7'b0000001 || int'(pos) !== 7) begin
            n_bad++; $display("FAIL areset_first: got flags=%b pos=%0d, want 0000001/7", {dir_up, dir_dn, ovf, unf, rsync, err, busy}, pos);
        end
    endtask

    task automatic test_random();
        int c;
        for (int unsigned i = 0; i < 600; i++) begin
            int unsigned r = $urandom_range(0, 99);
            if (r < 30)      c = (mp + 1) % 16;
            else if (r < 55) c = (mp + 15) % 16;
            else if (r < 70) c = mp;
            else if (r < 85) c = 0;
            else             c = $urandom_range(0, 15);
            apply(c, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
            n_vec++;
            if ({dir_up, dir_dn, ovf, unf, rsync, err, busy} !== {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK}) begin
                n_bad++; $display("FAIL random_flags step %0d: got %b, want %b", i,
                    {dir_up, dir_dn, ovf, unf, rsync, err, busy}, {e_up, e_dn, e_ovf, e_unf, e_rs, me, ms == M_TRACK});
            end
            n_vec++;
            if (int'(pos) !== mw * 16 + mp || int'(wrap_cnt) !== mw) begin
                n_bad++; $display("FAIL random_pos step %0d: got pos=%0d wrap=%0d, want %0d/%0d", i, pos, wrap_cnt, mw * 16 + mp, mw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_underflow();
        test_rsync();
        test_err();
        test_hold_vld();
        test_wrap_limit();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
